// File: rtl/cam_config_sequencer.sv
// Walks a config ROM after power-up and writes each {reg, value} entry to the camera over SCCB.
// Optional CAM_CFG_PWDN_EN adds a power-down/reset release sequence ahead of the first fetch.
module cam_config_sequencer #(
  parameter int         SCCB_DIV       = 250,
  parameter int         ROM_ADDR_WIDTH = 8,
  parameter logic [7:0] DEVICE_ADDR    = 8'h42,
  parameter int         DELAY_TICKS    = 100000
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      start_i,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [15:0]               rom_data_i,
  output logic                      sioc_o,
  output logic                      siod_o,
  output logic                      siod_oe_o,
  output logic                      busy_o,
  output logic                      done_o
`ifdef CAM_CFG_PWDN_EN
  ,
  output logic                      cam_pwdn_o,
  output logic                      cam_reset_no
`endif
);

  localparam int DW = $clog2(SCCB_DIV + 1);
  localparam int TW = $clog2(DELAY_TICKS + 1);

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef CAM_CFG_PWDN_EN
    S_PWR,
`endif
    S_FETCH,
    S_DECODE,
    S_DELAY,
    S_START,
    S_BITS,
    S_STOP,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [1:0]    quarter;
  logic [4:0]    bit_cnt;
  logic [26:0]   shreg;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    unit_cnt;
  logic          qtick;
  logic          tick_last;
  logic          bus_active;
  logic          advance;
`ifdef CAM_CFG_PWDN_EN
  logic          pwr_phase;
`endif

  assign bus_active = (state == S_START) || (state == S_BITS) ||
                      (state == S_STOP)  || (state == S_GAP);
  assign qtick      = (div_cnt == DW'(SCCB_DIV - 1));
  assign tick_last  = (tick_cnt == TW'(DELAY_TICKS - 1));

  // Divider only runs during bus states so every transfer starts on a full quarter.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div_cnt <= '0;
    end else if (!bus_active || qtick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_comb begin
    advance = 1'b0;
    case (state)
      S_DECODE: advance = (rom_data_i[15:8] == 8'hFE) && (rom_data_i[7:0] == 8'h00);
      S_DELAY:  advance = tick_last && (unit_cnt == 8'd1);
      S_GAP:    advance = qtick && (quarter == 2'd3);
      default:  advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= S_IDLE;
      quarter    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tick_cnt   <= '0;
      unit_cnt   <= '0;
      rom_addr_o <= '0;
      sioc_o     <= 1'b1;
      siod_o     <= 1'b1;
      siod_oe_o  <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
`ifdef CAM_CFG_PWDN_EN
      pwr_phase    <= 1'b0;
      cam_pwdn_o   <= 1'b1;
      cam_reset_no <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            rom_addr_o <= '0;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            tick_cnt   <= '0;
`ifdef CAM_CFG_PWDN_EN
            pwr_phase    <= 1'b0;
            cam_pwdn_o   <= 1'b0;
            cam_reset_no <= 1'b0;
            state        <= S_PWR;
`else
            state      <= S_FETCH;
`endif
          end
        end
`ifdef CAM_CFG_PWDN_EN
        S_PWR: begin
          tick_cnt <= tick_cnt + TW'(1);
          if (tick_last) begin
            tick_cnt <= '0;
            if (!pwr_phase) begin
              pwr_phase    <= 1'b1;
              cam_reset_no <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
`endif
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (rom_data_i == 16'hFFFF) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (rom_data_i[15:8] == 8'hFE) begin
            if (rom_data_i[7:0] != 8'h00) begin
              unit_cnt <= rom_data_i[7:0];
              tick_cnt <= '0;
              state    <= S_DELAY;
            end
          end else begin
            // Trailing 1 of each byte is the don't-care slot, sent with the pad released.
            shreg     <= {DEVICE_ADDR, 1'b1, rom_data_i[15:8], 1'b1, rom_data_i[7:0], 1'b1};
            quarter   <= '0;
            sioc_o    <= 1'b1;
            siod_o    <= 1'b0;
            siod_oe_o <= 1'b1;
            state     <= S_START;
          end
        end
        S_DELAY: begin
          tick_cnt <= tick_cnt + TW'(1);
          if (tick_last) begin
            tick_cnt <= '0;
            unit_cnt <= unit_cnt - 8'd1;
          end
        end
        S_START: begin
          if (qtick) begin
            if (quarter == 2'd0) begin
              quarter <= 2'd1;
              sioc_o  <= 1'b0;
            end else begin
              quarter   <= 2'd0;
              bit_cnt   <= '0;
              siod_o    <= shreg[26];
              siod_oe_o <= 1'b1;
              shreg     <= {shreg[25:0], 1'b0};
              state     <= S_BITS;
            end
          end
        end
        S_BITS: begin
          if (qtick) begin
            quarter <= quarter + 2'd1;
            if (quarter == 2'd1) begin
              sioc_o <= 1'b1;
            end else if (quarter == 2'd3) begin
              sioc_o <= 1'b0;
              if (bit_cnt == 5'd26) begin
                siod_o    <= 1'b0;
                siod_oe_o <= 1'b1;
                state     <= S_STOP;
              end else begin
                bit_cnt   <= bit_cnt + 5'd1;
                siod_o    <= shreg[26];
                siod_oe_o <= !((bit_cnt == 5'd7) || (bit_cnt == 5'd16) || (bit_cnt == 5'd25));
                shreg     <= {shreg[25:0], 1'b0};
              end
            end
          end
        end
        S_STOP: begin
          if (qtick) begin
            quarter <= quarter + 2'd1;
            if (quarter == 2'd0) begin
              sioc_o <= 1'b1;
            end else if (quarter == 2'd1) begin
              siod_o <= 1'b1;
            end else begin
              quarter <= 2'd0;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (qtick) quarter <= quarter + 2'd1;
        end
        default: state <= S_IDLE;
      endcase

      // A missing end marker terminates at the last address rather than wrapping.
      if (advance) begin
        if (&rom_addr_o) begin
          state  <= S_DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end else begin
          rom_addr_o <= rom_addr_o + ROM_ADDR_WIDTH'(1);
          state      <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Directed bench for cam_config_sequencer: decodes the SCCB waveform into frames and checks timing.
module tb_cam_config_sequencer;

  logic        clk_i;
  logic        reset_ni;
  logic        start_i;
  logic [1:0]  rom_addr_o;
  logic [15:0] rom_data_i;
  logic        sioc_o;
  logic        siod_o;
  logic        siod_oe_o;
  logic        busy_o;
  logic        done_o;
`ifdef CAM_CFG_PWDN_EN
  logic        cam_pwdn_o;
  logic        cam_reset_no;
`endif

  cam_config_sequencer #(
    .SCCB_DIV       (4),
    .ROM_ADDR_WIDTH (2),
    .DEVICE_ADDR    (8'h42),
    .DELAY_TICKS    (10)
  ) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .start_i    (start_i),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .sioc_o     (sioc_o),
    .siod_o     (siod_o),
    .siod_oe_o  (siod_oe_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef CAM_CFG_PWDN_EN
    ,
    .cam_pwdn_o   (cam_pwdn_o),
    .cam_reset_no (cam_reset_no)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [15:0] rom [4];
  always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Bus decoder: effective line is pulled high whenever the pad is released.
  logic [26:0] fr_dat[$];
  logic [26:0] fr_oe[$];
  int          fr_edges[$];
  logic        in_frame = 1'b0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic [26:0] cur_dat;
  logic [26:0] cur_oe;
  int          cur_edges;

  always @(negedge clk_i) begin
    logic sda;
    sda = siod_oe_o ? siod_o : 1'b1;
    if (!reset_ni) begin
      in_frame = 1'b0;
    end else if (prev_scl && sioc_o && prev_sda && !sda) begin
      in_frame  = 1'b1;
      cur_dat   = '0;
      cur_oe    = '0;
      cur_edges = 0;
    end else if (in_frame && !prev_scl && sioc_o) begin
      if (cur_edges < 27) begin
        cur_dat = {cur_dat[25:0], sda};
        cur_oe  = {cur_oe[25:0], siod_oe_o};
      end
      cur_edges++;
    end else if (in_frame && prev_scl && sioc_o && !prev_sda && sda) begin
      fr_dat.push_back(cur_dat);
      fr_oe.push_back(cur_oe);
      fr_edges.push_back(cur_edges);
      in_frame = 1'b0;
    end
    prev_scl = sioc_o;
    prev_sda = sda;
  end

  task automatic clear_frames();
    fr_dat.delete();
    fr_oe.delete();
    fr_edges.delete();
  endtask

  task automatic check_frame(input int idx, input logic [7:0] reg_a, input logic [7:0] val);
    logic [26:0] d;
    if (idx < fr_dat.size()) begin
      d = fr_dat[idx];
      chk("frame_dev", {24'd0, d[26:19]}, 32'h42);
      chk("frame_reg", {24'd0, d[17:10]}, {24'd0, reg_a});
      chk("frame_val", {24'd0, d[8:1]}, {24'd0, val});
      chk("frame_oe", {5'd0, fr_oe[idx]}, {5'd0, 27'b111111110_111111110_111111110});
      chk("frame_edges", fr_edges[idx], 28);
    end else begin
      chk("frame_present", idx, fr_dat.size());
    end
  endtask

  // Pulses start, then counts cycles until done_o; optionally re-pulses start mid-pass.
  task automatic run_pass(input int restart_at, output int cycles, output int first_low);
    cycles    = 0;
    first_low = -1;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    while (!done_o && cycles < 3000) begin
      @(posedge clk_i);
      #1;
      cycles++;
      start_i = (cycles == restart_at);
      if (first_low < 0 && siod_oe_o && !siod_o) first_low = cycles;
    end
    start_i = 1'b0;
    chk("pass_timeout", {31'd0, done_o}, 32'd1);
  endtask

  int cyc;
  int low;

  initial begin
    reset_ni = 1'b0;
    start_i  = 1'b0;
    for (int i = 0; i < 4; i++) rom[i] = 16'hFFFF;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_sioc", {31'd0, sioc_o}, 1);
    chk("rst_siod", {31'd0, siod_o}, 1);
    chk("rst_oe", {31'd0, siod_oe_o}, 1);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_done", {31'd0, done_o}, 0);
    chk("rst_addr", {30'd0, rom_addr_o}, 0);

    // Single write 42/12/80 then end marker.
    rom[0] = 16'h1280;
    rom[1] = 16'hFFFF;
    clear_frames();
    run_pass(-1, cyc, low);
    chk("w1_cycles", cyc, 472);
    chk("w1_start_at", low, 2);
    chk("w1_addr", {30'd0, rom_addr_o}, 1);
    chk("w1_busy", {31'd0, busy_o}, 0);
    chk("w1_done", {31'd0, done_o}, 1);
    chk("w1_frames", fr_dat.size(), 1);
    check_frame(0, 8'h12, 8'h80);

    // Delay of 3 units (30 cycles) before a single write.
    rom[0] = 16'hFE03;
    rom[1] = 16'h1100;
    rom[2] = 16'hFFFF;
    clear_frames();
    run_pass(-1, cyc, low);
    chk("dly_cycles", cyc, 504);
    chk("dly_start_at", low, 34);
    chk("dly_addr", {30'd0, rom_addr_o}, 2);
    chk("dly_frames", fr_dat.size(), 1);
    check_frame(0, 8'h11, 8'h00);

    // A second start while busy must change nothing.
    rom[0] = 16'h1280;
    rom[1] = 16'hFFFF;
    clear_frames();
    run_pass(100, cyc, low);
    chk("rs_cycles", cyc, 472);
    chk("rs_start_at", low, 2);
    chk("rs_addr", {30'd0, rom_addr_o}, 1);
    chk("rs_frames", fr_dat.size(), 1);
    check_frame(0, 8'h12, 8'h80);

    // Reset inside slot 5 of the register byte (overall slot 13, bit 3 of 0x12 = 0).
    clear_frames();
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (219) @(posedge clk_i);
    #1;
    chk("mid_busy", {31'd0, busy_o}, 1);
    chk("mid_sioc", {31'd0, sioc_o}, 0);
    chk("mid_siod", {31'd0, siod_o}, 0);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("ar_sioc", {31'd0, sioc_o}, 1);
    chk("ar_siod", {31'd0, siod_o}, 1);
    chk("ar_oe", {31'd0, siod_oe_o}, 1);
    chk("ar_busy", {31'd0, busy_o}, 0);
    chk("ar_done", {31'd0, done_o}, 0);
    chk("ar_addr", {30'd0, rom_addr_o}, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    clear_frames();
    run_pass(-1, cyc, low);
    chk("ar_pass_cycles", cyc, 472);
    chk("ar_pass_addr", {30'd0, rom_addr_o}, 1);
    chk("ar_pass_frames", fr_dat.size(), 1);
    check_frame(0, 8'h12, 8'h80);

    // No end marker: four writes, then stop at the last address.
    rom[0] = 16'h1111;
    rom[1] = 16'h2222;
    rom[2] = 16'h3A5C;
    rom[3] = 16'h44C3;
    clear_frames();
    run_pass(-1, cyc, low);
    chk("wrap_cycles", cyc, 1880);
    chk("wrap_addr", {30'd0, rom_addr_o}, 3);
    chk("wrap_busy", {31'd0, busy_o}, 0);
    chk("wrap_frames", fr_dat.size(), 4);
    check_frame(0, 8'h11, 8'h11);
    check_frame(1, 8'h22, 8'h22);
    check_frame(2, 8'h3A, 8'h5C);
    check_frame(3, 8'h44, 8'hC3);
    repeat (20) @(posedge clk_i);
    #1;
    chk("wrap_idle_addr", {30'd0, rom_addr_o}, 3);
    chk("wrap_idle_sioc", {31'd0, sioc_o}, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cam_config_sequencer.md
Name: cam_config_sequencer

Overview:
- Programs the CMOS camera's registers over SCCB (3-phase write) from a small synchronous config ROM after power-up, before the VRAM write path starts capturing frames.
- Walks ROM entries of the form {reg_addr[15:8], value[7:0]}.
- Supports end-marker and delay entries.
- Signals done so top-level logic can enable capture.

Parameters:
- SCCB_DIV, 250, clk_i cycles per SCCB quarter-bit (100 MHz gives 100 kHz SIOC).
- ROM_ADDR_WIDTH, 8, width of rom_addr_o.
- DEVICE_ADDR, 8'h42, SCCB write ID byte sent as phase 1.
- DELAY_TICKS, 100000, clk_i cycles per delay unit (1 ms at 100 MHz).

Ports:
- clk_i  input  1  system clock
- reset_ni  input  1  asynchronous active-low reset
- start_i  input  1  one-cycle pulse; begins a config pass from ROM address 0
- rom_addr_o  output  ROM_ADDR_WIDTH  config ROM address; ROM has 1-cycle read latency
- rom_data_i  input  16  ROM entry {reg, value}
- sioc_o  output  1  SCCB clock
- siod_o  output  1  SCCB data value
- siod_oe_o  output  1  1 = drive siod_o; 0 = release (pad pulled up)
- busy_o  output  1  high from accepted start_i until DONE
- done_o  output  1  level, high after end marker reached; cleared by next start_i

Behaviour:
- Reset: all outputs and all counters are 0, except sioc_o=1, siod_o=1, siod_oe_o=1 (bus idle high). State is IDLE.
- Clocking: a quarter-tick strobe fires every SCCB_DIV cycles; the divider counter is held at 0 in IDLE and DONE. Every SCCB state advance occurs only on a strobe.
- start_i is accepted only in IDLE or DONE. It sets rom_addr_o=0 and busy_o=1, clears done_o, and moves to FETCH. start_i in any other state is ignored.
- FETCH: waits 1 cycle for ROM data, then DECODE.
- DECODE:
  - 16'hFFFF goes to DONE.
  - Upper byte 8'hFE is a delay entry: go to DELAY for rom_data_i[7:0] x DELAY_TICKS cycles. A value of 0 means no wait.
  - Anything else latches the entry and goes to START.
- START (2 quarters): first siod_o=0 with sioc_o=1, then sioc_o=0.
- BITS: 27 bit slots = 3 phases (DEVICE_ADDR, reg, value) x 9 bits, MSB first.
  - Each slot is 4 quarters:
    - Q0: sioc_o=0, siod_o updates.
    - Q1: sioc_o=0.
    - Q2: sioc_o=1.
    - Q3: sioc_o=1.
  - The 9th slot of each phase is don't-care: siod_oe_o=0. ACK is not sampled.
- STOP (3 quarters): sioc_o=0/siod_o=0, then sioc_o=1, then siod_o=1.
- GAP: 4 quarters with the bus idle high.
- After GAP or DELAY, rom_addr_o increments and the state goes to FETCH.
- Address wrap: if rom_addr_o is all ones when it would increment, go to DONE instead (missing end marker).
- DONE: busy_o=0, done_o=1, bus idle high.
- Reset asserted mid-transaction: immediate return to the reset state. The bus is released high and may leave the camera with a truncated write, which the next pass rewrites.

Optional Feature:
- CAM_CFG_PWDN_EN:
  - When defined, adds output ports cam_pwdn_o (reset value 1) and cam_reset_no (reset value 0).
  - On accepted start_i, the block first enters PWR:
    - cam_pwdn_o=0 and cam_reset_no=0 for DELAY_TICKS cycles;
    - then cam_reset_no=1 and a further DELAY_TICKS wait;
    - then FETCH.
  - Without the macro, these ports and PWR do not exist, and start_i goes directly to FETCH.

Test Plan:
- Reset with SCCB_DIV=4, DELAY_TICKS=10 -> sioc_o=1, siod_o=1, siod_oe_o=1, busy_o=0, done_o=0, rom_addr_o=0.
- ROM {16'h1280, 16'hFFFF}, pulse start_i -> SIOC/SIOD decode to start, 42 x, 12 x, 80 x, stop.
  - siod_oe_o=0 in slots 9, 18 and 27.
  - done_o=1 and busy_o=0 after rom_addr_o reaches 1.
- ROM {16'hFE03, 16'h1100, 16'hFFFF} -> no SCCB activity for 30 cycles after DECODE, then one write 42/11/00, then DONE.
- start_i pulsed again while busy_o=1 -> ignored; rom_addr_o sequence and bus waveform identical to the single-start run.
- reset_ni low during BITS slot 5 of phase 2 -> same cycle, all outputs return to reset values. A new start_i restarts from rom_addr_o=0.
- ROM filled with no 16'hFFFF (ROM_ADDR_WIDTH=2) -> 4 writes issued, then DONE without wrapping to address 0.
